mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_arb_pkg.sv | 20 ++
 rtl/rr_pick4.sv | 25 ++
 rtl/mux4_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned HOLD_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Registered grant bundle driven to the shared channel.
  typedef struct packed {
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               valid;
  } grant_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping 3 -> 0.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [SEL_W-1:0]   win_idx,
  output logic               win_any
);

  // Walk offsets from farthest to nearest so the nearest hit is assigned last.
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        win_idx = ptr + SEL_W'(k);
        win_any = 1'b1;
      end
    end
    win_oh = win_any ? (NUM_REQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 data mux with registered one-hot grant.
// Define MUX4_ARB_HOLD_EN to let an owner keep the grant for up to MAX_HOLD cycles.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] i,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       valid,
  output logic       y
);

  if (MAX_HOLD == 0 || MAX_HOLD > 15) begin : g_max_hold_check
    $error("MAX_HOLD must be within 1..15");
  end

  arb_state_e         state_q, state_d;
  grant_t             grant_q, grant_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] pick_oh;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               rearb;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_any (pick_any)
  );

`ifdef MUX4_ARB_HOLD_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Owner keeps the channel while it still requests and has budget left.
  always_comb begin
    rearb = 1'b1;
    if (state_q == BUSY && req[grant_q.sel] && hold_q != HOLD_MAX) begin
      rearb = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Without hold, every edge is an arbitration point.
  always_comb begin
    rearb = 1'b1;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = BUSY;
      BUSY:    if (rearb && !pick_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered grant, pointer and hold count; sel holds when idle.
  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
`ifdef MUX4_ARB_HOLD_EN
    hold_d  = hold_q;
`endif
    if (rearb) begin
      if (pick_any) begin
        grant_d.gnt   = pick_oh;
        grant_d.sel   = pick_idx;
        grant_d.valid = 1'b1;
        ptr_d         = pick_idx + SEL_W'(1);
`ifdef MUX4_ARB_HOLD_EN
        hold_d        = HOLD_W'(1);
`endif
      end else begin
        grant_d.gnt   = '0;
        grant_d.valid = 1'b0;
      end
    end else begin
`ifdef MUX4_ARB_HOLD_EN
      hold_d = hold_q + HOLD_W'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt   = grant_q.gnt;
  assign s1    = grant_q.sel[1];
  assign s0    = grant_q.sel[0];
  assign valid = grant_q.valid;
  assign y     = grant_q.valid & i[grant_q.sel];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed table, corner sequences, random vs. model.
module tb_mux4_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic       s1, s0, valid, y;

  int n_checks = 0;
  int n_fail   = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .i     (din),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .valid (valid),
    .y     (y)
  );

  always #5 clk = ~clk;

  // Reference: owner index (-1 = idle), rotating pointer, hold count, last select.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_sel   = 0;

  function automatic int rr_first(input logic [3:0] r, input int from);
    for (int k = 0; k < 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic rv, input logic [3:0] r);
    bit rearb;
    int w;
    if (!rv) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
      return;
    end
    rearb = 1'b1;
`ifdef MUX4_ARB_HOLD_EN
    if (m_owner >= 0 && r[m_owner] && m_hold < MAXH) begin
      rearb = 1'b0;
      m_hold++;
    end
`endif
    if (rearb) begin
      w = rr_first(r, m_ptr);
      if (w < 0) begin
        m_owner = -1;
      end else begin
        m_owner = w; m_sel = w; m_ptr = (w + 1) % 4; m_hold = 1;
      end
    end
  endtask

  task automatic cyc(input logic rv, input logic [3:0] r, input logic [3:0] d);
    rst_n = rv;
    req   = r;
    din   = d;
    @(posedge clk);
    model_edge(rv, r);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                       input logic ev, input logic ey);
    n_checks++;
    if (gnt !== eg || {s1, s0} !== es || valid !== ev || y !== ey) begin
      n_fail++;
      $display("FAIL %s t=%0t: got gnt=%b sel=%b valid=%b y=%b, want gnt=%b sel=%b valid=%b y=%b",
               name, $time, gnt, {s1, s0}, valid, y, eg, es, ev, ey);
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] eg;
    logic       ev;
    logic       ey;
    ev = (m_owner >= 0);
    eg = ev ? 4'(1 << m_owner) : 4'b0000;
    ey = ev ? din[m_sel] : 1'b0;
    check(name, eg, 2'(m_sel), ev, ey);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       y;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [3:0] d;
    logic [3:0] r;
    int         idx;

    rst_n = 1'b0;
    req   = 4'b0000;
    din   = 4'b0000;

    vecs[0] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 2'b10, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 2'b10, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 4'b1001, 4'b1111, 4'b1000, 2'b11, 1'b1, 1'b1};

    for (int k = 0; k < 7; k++) begin
      cyc(vecs[k].rst, vecs[k].req, vecs[k].din);
      check($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].sel, vecs[k].valid, vecs[k].y);
    end

    // Rotation with all requesters active.
    cyc(1'b0, 4'b1111, 4'b0000);
    d = 4'b1010;
`ifdef MUX4_ARB_HOLD_EN
    for (int c = 0; c < 17; c++) begin
      cyc(1'b1, 4'b1111, d);
      idx = (c / MAXH) % 4;
      check($sformatf("hold_rot%0d", c), 4'(1 << idx), 2'(idx), 1'b1, d[idx]);
    end
`else
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 4'b0101, d);
      idx = (c % 2 == 0) ? 0 : 2;
      check($sformatf("alt%0d", c), 4'(1 << idx), 2'(idx), 1'b1, d[idx]);
    end
`endif

    // Early release hands over without an idle bubble.
    cyc(1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 4'b1001, 4'b0000);
    check("early_first", 4'b0001, 2'b00, 1'b1, 1'b0);
    cyc(1'b1, 4'b1000, 4'b1000);
    check("early_handoff", 4'b1000, 2'b11, 1'b1, 1'b1);

    // Reset in the middle of a grant.
    cyc(1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 4'b0010, 4'b0010);
    check("mid_grant", 4'b0010, 2'b01, 1'b1, 1'b1);
    cyc(1'b0, 4'b1111, 4'b1111);
    check("mid_reset", 4'b0000, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 4'b1111, 4'b0001);
    check("post_reset", 4'b0001, 2'b00, 1'b1, 1'b1);

    // Random traffic with persistent requests and rare resets.
    cyc(1'b0, 4'b0000, 4'b0000);
    check_model("rand_reset");
    r = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      cyc(($urandom_range(0, 99) != 0), r, 4'($urandom));
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
